// File: rtl/instr_mem_sync_if.sv
// Fetch/load bus between the PC stage and the synchronous LC2K instruction memory.
// master = fetch/load requester, slave = memory.
interface instr_mem_sync_if #(
    parameter int DATA_W = 32
);
    logic              load_en;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;
    logic              fetch_req;
    logic [31:0]       fetch_pc;
    logic              fetch_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              fetch_fault;

    modport master (
        output load_en, load_addr, load_data, fetch_req, fetch_pc,
        input  load_err, fetch_ready, instr_valid, instr, fetch_fault
    );

    modport slave (
        input  load_en, load_addr, load_data, fetch_req, fetch_pc,
        output load_err, fetch_ready, instr_valid, instr, fetch_fault
    );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous LC2K instruction memory: registered 1-cycle fetch, program-load port, hardware clear after reset.
// Optional macro INSTR_MEM_WR_BYPASS_EN selects write-first forwarding on same-address load/fetch collisions.
module instr_mem_sync #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(32'h0180_0000)
) (
    input logic              clk,
    input logic              reset_n,
    instr_mem_sync_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_clr_cnt;
    logic [AW-1:0]     w_clr_cnt_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_load_in_range;
    logic              w_fetch_in_range;
    logic              w_load_ok;
    logic              w_load_bad;
    logic              w_fetch_acc;
    logic [AW-1:0]     w_load_idx;
    logic [AW-1:0]     w_fetch_idx;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_instr_valid;
    logic              r_fetch_fault;
    logic              r_load_err;
    logic [DATA_W-1:0] r_instr;

    // Full 32-bit compares: out-of-range addresses must never alias into the array.
    assign w_load_in_range  = (bus.load_addr < 32'(DEPTH));
    assign w_fetch_in_range = (bus.fetch_pc < 32'(DEPTH));
    assign w_load_idx       = bus.load_addr[AW-1:0];
    assign w_fetch_idx      = bus.fetch_pc[AW-1:0];

    assign w_load_ok   = (r_state == READY) && bus.load_en && w_load_in_range;
    assign w_load_bad  = (r_state == READY) && bus.load_en && !w_load_in_range;
    assign w_fetch_acc = (r_state == READY) && bus.fetch_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear sequence and program loads share the single write port.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_wr_en       = 1'b0;
        w_wr_addr     = w_load_idx;
        w_wr_data     = bus.load_data;
        case (r_state)
            CLEAR: begin
                w_wr_en       = reset_n;
                w_wr_addr     = r_clr_cnt;
                w_wr_data     = '0;
                w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                if (r_clr_cnt == AW'(DEPTH - 1)) begin
                    w_state_nxt   = READY;
                    w_clr_cnt_nxt = '0;
                end
            end
            READY: begin
                w_wr_en = reset_n && w_load_ok;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

`ifdef INSTR_MEM_WR_BYPASS_EN
    always_comb begin
        w_rd_data = r_mem[w_fetch_idx];
        if (w_load_ok && (bus.load_addr == bus.fetch_pc)) begin
            w_rd_data = bus.load_data;
        end
    end
`else
    // Read-first: the array still holds the pre-write word at this edge.
    always_comb begin
        w_rd_data = r_mem[w_fetch_idx];
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_acc;
            r_fetch_fault <= w_fetch_acc && !w_fetch_in_range;
            r_load_err    <= w_load_bad;
            if (w_fetch_acc) begin
                r_instr <= w_fetch_in_range ? w_rd_data : HALT_WORD;
            end
        end
    end

    assign bus.fetch_ready = (r_state == READY);
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_fault = r_fetch_fault;
    assign bus.load_err    = r_load_err;
    assign bus.instr       = r_instr;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Randomized self-checking bench for instr_mem_sync against an array-based behavioural model.
// Honours INSTR_MEM_WR_BYPASS_EN for the expected collision result.
module tb_instr_mem_sync;
    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam logic [31:0] HALT   = 32'h0180_0000;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    instr_mem_sync_if #(.DATA_W(DATA_W)) bus ();

    instr_mem_sync #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .HALT_WORD(HALT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: word array plus count of completed clear edges.
    logic [31:0] model_mem [DEPTH];
    int          clr_done;
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_fault;
    logic        exp_lerr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic ld_en, input logic [31:0] ld_a,
                        input logic [31:0] ld_d, input logic f_req, input logic [31:0] f_pc);
        reset_n       = rst_n;
        bus.load_en   = ld_en;
        bus.load_addr = ld_a;
        bus.load_data = ld_d;
        bus.fetch_req = f_req;
        bus.fetch_pc  = f_pc;
        @(posedge clk);
        if (!rst_n) begin
            clr_done  = 0;
            exp_instr = '0;
            exp_valid = 1'b0;
            exp_fault = 1'b0;
            exp_lerr  = 1'b0;
        end else if (clr_done < DEPTH) begin
            model_mem[clr_done] = '0;
            clr_done++;
            exp_valid = 1'b0;
            exp_fault = 1'b0;
            exp_lerr  = 1'b0;
        end else begin
            exp_valid = f_req;
            exp_fault = f_req && (f_pc >= DEPTH);
            if (f_req) exp_instr = (f_pc >= DEPTH) ? HALT : model_mem[f_pc];
`ifdef INSTR_MEM_WR_BYPASS_EN
            if (f_req && ld_en && (ld_a == f_pc) && (ld_a < DEPTH)) exp_instr = ld_d;
`endif
            exp_lerr = ld_en && (ld_a >= DEPTH);
            if (ld_en && (ld_a < DEPTH)) model_mem[ld_a] = ld_d;
        end
        #1;
        check_eq("fetch_ready", 32'(bus.fetch_ready), 32'(clr_done == DEPTH));
        check_eq("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
        check_eq("fetch_fault", 32'(bus.fetch_fault), 32'(exp_fault));
        check_eq("load_err",    32'(bus.load_err),    32'(exp_lerr));
        check_eq("instr",       bus.instr,            exp_instr);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic fetch(input logic [31:0] pc);
        step(1'b1, 1'b0, '0, '0, 1'b1, pc);
    endtask

    task automatic clear_with_noise();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b1, $urandom_range(0, DEPTH + 4), $urandom, 1'b1, $urandom_range(0, DEPTH - 1));
        end
    endtask

    logic [31:0] prog [3];
    logic [31:0] ra, rd, rp;
    logic        rl, rf, rr;

    initial begin
        prog[0] = 32'h0081_000A;
        prog[1] = 32'h0082_0009;
        prog[2] = 32'h0180_0000;
        clr_done = 0;
        exp_instr = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0);
        clear_with_noise();
        fetch(32'd5);
        check_eq("pc5_after_clear", bus.instr, 32'h0);

        for (int i = 0; i < 3; i++) load(32'(i), prog[i]);
        for (int i = 0; i < 3; i++) begin
            fetch(32'(i));
            check_eq("prog_word", bus.instr, prog[i]);
        end
        idle();

        fetch(32'd64);
        check_eq("halt_pc64", bus.instr, HALT);
        fetch(32'hFFFF_FFFF);
        check_eq("halt_pcmax", bus.instr, HALT);

        load(32'd64, 32'h1234);
        check_eq("load_err_pulse", 32'(bus.load_err), 32'd1);
        idle();
        check_eq("load_err_drop", 32'(bus.load_err), 32'd0);
        fetch(32'd0);
        check_eq("pc0_unchanged", bus.instr, prog[0]);

        load(32'd3, 32'hAAAA);
        step(1'b1, 1'b1, 32'd3, 32'h5555, 1'b1, 32'd3);
`ifdef INSTR_MEM_WR_BYPASS_EN
        check_eq("collision", bus.instr, 32'h5555);
`else
        check_eq("collision", bus.instr, 32'hAAAA);
`endif
        fetch(32'd3);
        check_eq("after_collision", bus.instr, 32'h5555);

        fetch(32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 32'd1);
        check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instr, 32'h0);
        clear_with_noise();
        fetch(32'd0);
        check_eq("recleared_pc0", bus.instr, 32'h0);
        fetch(32'd1);
        check_eq("recleared_pc1", bus.instr, 32'h0);

        // Random traffic, including occasional resets (some landing mid-clear).
        for (int n = 0; n < 1500; n++) begin
            rr = ($urandom_range(0, 299) != 0);
            rl = $urandom_range(0, 1)[0];
            rf = ($urandom_range(0, 3) != 0);
            rd = $urandom;
            ra = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH + 3);
            rp = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, DEPTH + 3);
            if ($urandom_range(0, 5) == 0) rp = ra;
            step(rr, rl, ra, rd, rf, rp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
